// File: rtl/psr_bank_ctrl.sv
// CPSR plus banked SPSRs with a small exception entry/return sequencer.
// Exceptions are prioritised, CPSR is saved into the target bank, then the mode switches and a vector is issued.
module psr_bank_ctrl #(
  parameter logic [31:0] RESET_CPSR = 32'h0000_0010,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter bit          HAS_MON    = 1'b1,
  parameter bit          HAS_HYP    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  exc_req,
  input  logic        msr_we,
  input  logic        msr_spsr,
  input  logic [3:0]  msr_mask,
  input  logic [31:0] msr_data,
  input  logic        flags_we,
  input  logic [3:0]  flags_nzcv,
  input  logic        ret_req,
  output logic [31:0] cpsr,
  output logic [31:0] spsr_cur,
  output logic        exc_ack,
  output logic [2:0]  exc_id,
  output logic [31:0] vec_addr,
  output logic        ret_ack,
  output logic        ret_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAVE   = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;
  localparam logic [1:0] S_RET    = 2'd3;

  localparam logic [2:0] B_FIQ  = 3'd0;
  localparam logic [2:0] B_IRQ  = 3'd1;
  localparam logic [2:0] B_SVC  = 3'd2;
  localparam logic [2:0] B_MON  = 3'd3;
  localparam logic [2:0] B_ABT  = 3'd4;
  localparam logic [2:0] B_HYP  = 3'd5;
  localparam logic [2:0] B_UND  = 3'd6;
  localparam logic [2:0] B_NONE = 3'd7;

  // dabt, pabt, und, svc are latched pulses; fiq/irq are sampled levels
  localparam logic [5:0] PULSE_M = 6'b111001;

  function automatic logic [2:0] bank_of(input logic [4:0] m);
    case (m)
      5'b10001: bank_of = B_FIQ;
      5'b10010: bank_of = B_IRQ;
      5'b10011: bank_of = B_SVC;
      5'b10110: bank_of = HAS_MON ? B_MON : B_NONE;
      5'b10111: bank_of = B_ABT;
      5'b11010: bank_of = HAS_HYP ? B_HYP : B_NONE;
      5'b11011: bank_of = B_UND;
      default:  bank_of = B_NONE;
    endcase
  endfunction

  function automatic logic [2:0] tgt_bank(input logic [2:0] id);
    case (id)
      3'd1:    tgt_bank = B_FIQ;
      3'd2:    tgt_bank = B_IRQ;
      3'd4:    tgt_bank = B_UND;
      3'd5:    tgt_bank = B_SVC;
      default: tgt_bank = B_ABT;
    endcase
  endfunction

  function automatic logic [4:0] tgt_mode(input logic [2:0] id);
    case (id)
      3'd1:    tgt_mode = 5'b10001;
      3'd2:    tgt_mode = 5'b10010;
      3'd4:    tgt_mode = 5'b11011;
      3'd5:    tgt_mode = 5'b10011;
      default: tgt_mode = 5'b10111;
    endcase
  endfunction

  function automatic logic [31:0] vec_off(input logic [2:0] id);
    case (id)
      3'd0:    vec_off = 32'h10;
      3'd1:    vec_off = 32'h1C;
      3'd2:    vec_off = 32'h18;
      3'd3:    vec_off = 32'h0C;
      3'd4:    vec_off = 32'h04;
      default: vec_off = 32'h08;
    endcase
  endfunction

  function automatic logic [31:0] mask_wr(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
    mask_wr = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) mask_wr[b*8 +: 8] = d[b*8 +: 8];
  endfunction

  logic [1:0]        r_state;
  logic [31:0]       r_cpsr;
  logic [7:0][31:0]  r_spsr;
  logic [5:0]        r_pend;
  logic [2:0]        r_id;

  logic [2:0]  w_cur_bank;
  logic        w_has_spsr;
  logic [5:0]  w_elig;
  logic        w_any;
  logic [2:0]  w_take_id;
  logic [5:0]  w_clr;
  logic [5:0]  w_set;
  logic [31:0] w_cpsr_upd;
  logic [31:0] w_spsr_upd;

  assign w_cur_bank = bank_of(r_cpsr[4:0]);
  assign w_has_spsr = (w_cur_bank != B_NONE);

  assign w_elig = {r_pend[5] | exc_req[5],
                   r_pend[4] | exc_req[4],
                   r_pend[3] | exc_req[3],
                   exc_req[2] & ~r_cpsr[7],
                   exc_req[1] & ~r_cpsr[6],
                   r_pend[0] | exc_req[0]};
  assign w_any = |w_elig;

  always_comb begin
    w_take_id = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (w_elig[i]) w_take_id = 3'(i);
  end

  assign w_clr = (r_state == S_IDLE && w_any) ? (6'b1 << w_take_id) : 6'b0;
  // A pulse consumed in its own arrival cycle is not latched; a fresh pulse
  // landing on an already-pending bit that is being taken stays pending.
  assign w_set = exc_req & PULSE_M & ~(w_clr & ~r_pend);

  always_comb begin
    w_cpsr_upd = r_cpsr;
    if (flags_we) w_cpsr_upd[31:28] = flags_nzcv;
    if (msr_we && !msr_spsr) w_cpsr_upd = mask_wr(w_cpsr_upd, msr_data, msr_mask);
  end

  assign w_spsr_upd = mask_wr(spsr_cur, msr_data, msr_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cpsr  <= RESET_CPSR;
      r_spsr  <= '0;
      r_pend  <= '0;
      r_id    <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      case (r_state)
        S_IDLE: begin
          r_cpsr <= w_cpsr_upd;
          if (msr_we && msr_spsr && w_has_spsr) r_spsr[w_cur_bank] <= w_spsr_upd;
          if (w_any) begin
            r_id    <= w_take_id;
            r_state <= S_SAVE;
          end else if (ret_req) begin
            r_state <= S_RET;
          end
        end
        S_SAVE: begin
          r_spsr[tgt_bank(r_id)] <= r_cpsr;
          r_state <= S_SWITCH;
        end
        S_SWITCH: begin
          r_cpsr[4:0] <= tgt_mode(r_id);
          r_cpsr[7]   <= 1'b1;
          r_cpsr[5]   <= 1'b0;
          if (r_id == 3'd1) r_cpsr[6] <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          if (w_has_spsr) r_cpsr <= spsr_cur;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpsr     = r_cpsr;
  assign spsr_cur = r_spsr[w_cur_bank];
  assign busy     = (r_state != S_IDLE);
  assign exc_ack  = (r_state == S_SWITCH);
  assign exc_id   = exc_ack ? r_id : 3'd0;
  assign vec_addr = exc_ack ? (VEC_BASE + vec_off(r_id)) : 32'd0;
  assign ret_ack  = (r_state == S_RET);
  assign ret_err  = ret_ack && !w_has_spsr;

endmodule

// File: tb/tb_psr_bank_ctrl.sv
// Bench for psr_bank_ctrl: MSR/flag vector table plus hand-written exception/return sequences,
// with acks checked against a queue of expected events.
module tb_psr_bank_ctrl;

  logic        clk, rst;
  logic [5:0]  exc_req;
  logic        msr_we, msr_spsr, flags_we, ret_req;
  logic [3:0]  msr_mask, flags_nzcv;
  logic [31:0] msr_data;
  logic [31:0] cpsr, spsr_cur, vec_addr;
  logic        exc_ack, ret_ack, ret_err, busy;
  logic [2:0]  exc_id;

  psr_bank_ctrl dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .msr_we(msr_we), .msr_spsr(msr_spsr),
    .msr_mask(msr_mask), .msr_data(msr_data), .flags_we(flags_we), .flags_nzcv(flags_nzcv),
    .ret_req(ret_req), .cpsr(cpsr), .spsr_cur(spsr_cur), .exc_ack(exc_ack), .exc_id(exc_id),
    .vec_addr(vec_addr), .ret_ack(ret_ack), .ret_err(ret_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ret;
    logic [2:0]  id;
    logic [31:0] vec;
    bit          err;
  } sb_t;

  typedef struct {
    bit          we;
    bit          sp;
    logic [3:0]  mask;
    logic [31:0] data;
    bit          fwe;
    logic [3:0]  nzcv;
    logic [31:0] e_cpsr;
    logic [31:0] e_spsr;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[11];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_exc(input logic [2:0] id, input logic [31:0] vec);
    sb_t e;
    e.is_ret = 1'b0; e.id = id; e.vec = vec; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_ret(input bit err);
    sb_t e;
    e.is_ret = 1'b1; e.id = 3'd0; e.vec = 32'd0; e.err = err;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample after the edge, retire any ack against the scoreboard
  task automatic tick();
    sb_t e;
    @(posedge clk); #1;
    if (exc_ack || ret_ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got exc_ack=%0b ret_ack=%0b expected none", exc_ack, ret_ack);
      end else begin
        e = sb.pop_front();
        chk("ack_kind", {30'd0, exc_ack, ret_ack}, e.is_ret ? 32'd1 : 32'd2);
        if (e.is_ret) chk("ret_err", {31'd0, ret_err}, {31'd0, e.err});
        else begin
          chk("exc_id", {29'd0, exc_id}, {29'd0, e.id});
          chk("vec_addr", vec_addr, e.vec);
        end
      end
    end
  endtask

  task automatic wait_ack(input string nm, output int n);
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (exc_ack || ret_ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", nm);
    end
  endtask

  task automatic do_ret(input bit err);
    int n;
    ret_req = 1'b1;
    push_ret(err);
    wait_ack("ret", n);
    ret_req = 1'b0;
    chk("ret_latency", n, 1);
    tick();
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    msr_we = v.we; msr_spsr = v.sp; msr_mask = v.mask; msr_data = v.data;
    flags_we = v.fwe; flags_nzcv = v.nzcv;
    tick();
    msr_we = 1'b0; flags_we = 1'b0;
    chk($sformatf("vec%0d_cpsr", idx), cpsr, v.e_cpsr);
    chk($sformatf("vec%0d_spsr", idx), spsr_cur, v.e_spsr);
  endtask

  initial begin
    int   n;
    vec_t v;
    tbl[0]  = '{1'b1, 1'b0, 4'b0100, 32'hAABB_CCDD, 1'b0, 4'h0, 32'h00BB_0010, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'b1000, 32'hF012_3456, 1'b0, 4'h0, 32'hF0BB_0010, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'b0010, 32'h0000_AB00, 1'b0, 4'h0, 32'hF0BB_AB10, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 4'b1111, 32'h1234_5678, 1'b0, 4'h0, 32'hF0BB_AB10, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'hF0BB_AB10, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'b1000, 32'h3000_0000, 1'b1, 4'h5, 32'h30BB_AB10, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 32'h0,         1'b1, 4'h9, 32'h90BB_AB10, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'b0001, 32'h0000_00D1, 1'b0, 4'h0, 32'h90BB_ABD1, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 4'b1111, 32'hCAFE_0010, 1'b0, 4'h0, 32'h90BB_ABD1, 32'hCAFE_0010};
    tbl[9]  = '{1'b1, 1'b1, 4'b0001, 32'h0000_00FF, 1'b0, 4'h0, 32'h90BB_ABD1, 32'hCAFE_00FF};
    tbl[10] = '{1'b1, 1'b1, 4'b1000, 32'h1100_0000, 1'b1, 4'h0, 32'h00BB_ABD1, 32'h11FE_00FF};

    rst = 1'b0; exc_req = '0; msr_we = 0; msr_spsr = 0; msr_mask = '0; msr_data = '0;
    flags_we = 0; flags_nzcv = '0; ret_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpsr", cpsr, 32'h10);
    chk("rst_spsr", spsr_cur, 32'h0);
    chk("rst_outs", {26'd0, busy, exc_ack, ret_ack, ret_err, exc_id != 3'd0, vec_addr != 32'd0}, 32'd0);
    rst = 1'b1;
    tick();

    // svc entry: ack two cycles after the pulse, busy for SAVE and SWITCH
    exc_req = 6'b100000; push_exc(3'd5, 32'h08);
    tick();
    exc_req = '0;
    chk("svc_busy_save", {31'd0, busy}, 32'd1);
    wait_ack("svc", n);
    chk("svc_ack_latency", n, 1);
    chk("svc_busy_switch", {31'd0, busy}, 32'd1);
    tick();
    chk("svc_busy_done", {31'd0, busy}, 32'd0);
    chk("svc_cpsr", cpsr, 32'h93);
    chk("svc_spsr", spsr_cur, 32'h10);
    do_ret(1'b0);
    chk("svc_ret_cpsr", cpsr, 32'h10);

    // dabt and irq together: dabt first, irq masked by I until return
    exc_req = 6'b000101; push_exc(3'd0, 32'h10);
    tick();
    exc_req = 6'b000100;
    wait_ack("dabt", n);
    tick();
    chk("dabt_cpsr", cpsr, 32'h97);
    chk("dabt_spsr", spsr_cur, 32'h10);
    repeat (3) begin
      tick();
      chk("irq_masked_busy", {31'd0, busy}, 32'd0);
    end
    do_ret(1'b0);
    chk("dabt_ret_cpsr", cpsr, 32'h10);
    push_exc(3'd2, 32'h18);
    wait_ack("irq", n);
    exc_req = '0;
    tick();
    chk("irq_cpsr", cpsr, 32'h92);
    chk("irq_spsr", spsr_cur, 32'h10);
    do_ret(1'b0);
    chk("irq_ret_cpsr", cpsr, 32'h10);

    // byte-masked MSR and flag updates from the table
    for (int i = 0; i < 11; i++) apply_vec(tbl[i], i);

    // fiq mode, F=1: fiq stays blocked, pabt still taken
    exc_req = 6'b001010; push_exc(3'd3, 32'h0C);
    tick();
    exc_req = 6'b000010;
    wait_ack("pabt", n);
    tick();
    chk("pabt_cpsr", cpsr, 32'h00BB_ABD7);
    chk("pabt_spsr", spsr_cur, 32'h00BB_ABD1);
    do_ret(1'b0);
    chk("pabt_ret_cpsr", cpsr, 32'h00BB_ABD1);
    tick();
    chk("fiq_blocked", {31'd0, busy}, 32'd0);
    exc_req = '0;
    v = '{1'b1, 1'b0, 4'b1111, 32'h0000_0010, 1'b0, 4'h0, 32'h10, 32'h0};
    apply_vec(v, 11);

    // flags in the detection cycle are saved; MSR while busy is dropped
    exc_req = 6'b010000; flags_we = 1'b1; flags_nzcv = 4'b1010; push_exc(3'd4, 32'h04);
    tick();
    exc_req = '0; flags_we = 1'b0;
    msr_we = 1'b1; msr_spsr = 1'b0; msr_mask = 4'b1111; msr_data = 32'hFFFF_FFFF;
    tick();
    msr_we = 1'b0;
    tick();
    chk("und_cpsr", cpsr, 32'hA000_009B);
    chk("und_spsr", spsr_cur, 32'hA000_0010);
    do_ret(1'b0);
    chk("und_ret_cpsr", cpsr, 32'hA000_0010);
    v = '{1'b1, 1'b0, 4'b1111, 32'h0000_0010, 1'b0, 4'h0, 32'h10, 32'h0};
    apply_vec(v, 12);

    // return from usr is an error and leaves CPSR alone
    do_ret(1'b1);
    chk("reterr_cpsr", cpsr, 32'h10);

    // async reset in the middle of SWITCH
    v = '{1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 4'hF, 32'hF000_0010, 32'h0};
    apply_vec(v, 13);
    exc_req = 6'b100000;
    tick();
    exc_req = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_outs", {28'd0, busy, exc_ack, ret_ack, ret_err}, 32'd0);
    chk("arst_vec", vec_addr, 32'd0);
    chk("arst_cpsr", cpsr, 32'h10);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) tick();
    chk("arst_idle", {31'd0, busy}, 32'd0);
    v = '{1'b1, 1'b0, 4'b0001, 32'h0000_0013, 1'b0, 4'h0, 32'h13, 32'h0};
    apply_vec(v, 14);
    v = '{1'b1, 1'b0, 4'b0001, 32'h0000_0010, 1'b0, 4'h0, 32'h10, 32'h0};
    apply_vec(v, 15);
    exc_req = 6'b100000; push_exc(3'd5, 32'h08);
    tick();
    exc_req = '0;
    wait_ack("svc2", n);
    tick();
    chk("svc2_cpsr", cpsr, 32'h93);
    chk("svc2_spsr", spsr_cur, 32'h10);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psr_bank_ctrl.md
Name: psr_bank_ctrl

Overview:
Parametrised successor to the CPSR/SPSR register block. It holds CPSR and the banked SPSRs, and runs a small exception entry/return state machine in place of mode-select muxing driven by the decoder. It takes prioritised exception requests, saves CPSR into the target bank, switches mode, and returns the vector address with a one-cycle ack. It sits between the control unit (MSR, flag update, exception return) and the fetch stage (vector redirect).

Parameters:
RESET_CPSR, 32'h0000_0010, CPSR value on reset (user mode).
VEC_BASE, 32'h0000_0000, exception vector base; vec_addr = VEC_BASE + offset.
HAS_MON, 1, include the monitor SPSR bank; if 0, reads return 0 and writes are dropped.
HAS_HYP, 1, include the hyp SPSR bank; same rule as HAS_MON.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
exc_req  in  6  bit0 dabt, bit1 fiq, bit2 irq, bit3 pabt, bit4 und, bit5 svc; lower index = higher priority.
msr_we  in  1  MSR write strobe.
msr_spsr  in  1  0 = write CPSR, 1 = write current-mode SPSR.
msr_mask  in  4  field mask {f,s,x,c} = bytes [31:24],[23:16],[15:8],[7:0].
msr_data  in  32  MSR write data.
flags_we  in  1  S-bit flag update strobe.
flags_nzcv  in  4  new NZCV.
ret_req  in  1  exception return request (CPSR <= current SPSR); level, held until ret_ack.
cpsr  out  32  current CPSR.
spsr_cur  out  32  SPSR of the current mode; 0 in usr/sys.
exc_ack  out  1  one-cycle pulse when exception entry completes.
exc_id  out  3  index of the taken exception; valid with exc_ack.
vec_addr  out  32  vector address; valid with exc_ack.
ret_ack  out  1  one-cycle pulse when return completes.
ret_err  out  1  with ret_ack: return attempted from usr/sys; CPSR unchanged.
busy  out  1  high in SAVE, SWITCH and RET.

Behaviour:
- Reset (rst=0, async): cpsr=RESET_CPSR; all SPSR banks=0; pending=0; state=IDLE; exc_ack, ret_ack, ret_err, exc_id, vec_addr, busy=0.
- Bank map (M[4:0]): fiq 10001, irq 10010, svc 10011, mon 10110, abt 10111, hyp 11010, und 11011. usr 10000 and sys 11111 have no SPSR. Any other M behaves as usr.
- Pending register:
  - dabt, pabt, und, svc: pulse inputs; a set bit stays set until that exception is taken. If set and clear coincide for the same bit, set wins.
  - irq, fiq: level inputs, not latched. irq is eligible only when CPSR[7]=0; fiq only when CPSR[6]=0.
- FSM states IDLE, SAVE, SWITCH, RET:
  - IDLE: apply msr_we / flags_we this cycle. If any eligible exception exists, latch the highest-priority id, clear its pending bit, go to SAVE. Otherwise, if ret_req, go to RET. An exception beats ret_req.
  - SAVE: spsr[target] <= cpsr. Go to SWITCH.
  - SWITCH: cpsr[4:0] <= target mode, cpsr[7](I) <= 1, cpsr[5](T) <= 0; cpsr[6](F) <= 1 only for fiq. Pulse exc_ack with exc_id and vec_addr. Go to IDLE. Entry latency is 2 cycles after detection.
  - RET: if the mode has an SPSR, cpsr <= spsr_cur, otherwise set ret_err. Pulse ret_ack. Go to IDLE.
- Target modes and vector offsets: dabt -> abt, +0x10; fiq -> fiq, +0x1C; irq -> irq, +0x18; pabt -> abt, +0x0C; und -> und, +0x04; svc -> svc, +0x08.
- MSR to CPSR: each byte is written only where its msr_mask bit is set.
- MSR to SPSR: same byte masking, applied to the current bank; dropped in usr/sys.
- flags_we: cpsr[31:28] <= flags_nzcv. If msr_we targets CPSR with mask[3] in the same cycle, MSR wins for [31:24].
- Updates in the IDLE cycle that detects an exception are visible to SAVE, so the saved SPSR contains them.
- msr_we and flags_we are dropped while busy=1; the issuer must stall on busy.
- Outputs cpsr and spsr_cur are registered state or a mux of it; there is no combinational path from inputs.

Test Plan:
- Reset and entry: release rst, pulse exc_req[5] (svc). Required: exc_ack after 2 cycles, exc_id=5, vec_addr=0x08, cpsr=0x0000_0093, spsr_svc=0x0000_0010, busy high for 2 cycles.
- Priority: exc_req[0] and exc_req[2] set together from usr. Required: dabt taken first (cpsr[4:0]=10111, I=1). irq is not taken while I=1. After ret_req, ret_ack, cpsr=0x10, irq is taken (vec_addr=0x18).
- Masking: MSR cpsr with mask=4'b0001, data=0x0000_00D1. Required: mode fiq, [31:8] unchanged. fiq then blocked by F=1; pending pabt pulse is still taken.
- Flags vs exception: flags_we=1, nzcv=4'b1010 in the same cycle as an und pulse. Required: spsr_und[31:28]=4'b1010; MSR issued during busy is dropped.
- Return error: ret_req in usr. Required: ret_ack=1 and ret_err=1 one cycle later, cpsr unchanged.
- Async reset: assert rst mid-SWITCH. Required: outputs 0 immediately, cpsr=RESET_CPSR, no exc_ack.
